mem_wb_stage: RTL and testbench

Pipeline register and write-back stage between the memory-access stage and the register file write port. It captures the MEM-stage result each cycle and honours stall and flush. For loads, it aligns and extends the synchronous data-memory read word. It drives the register file's `we`/`waddr`/`wdata` and keeps a retired-write counter.

---
 rtl/mem_wb_stage_if.sv | 22 ++
 rtl/mem_wb_stage.sv | 158 +++++++++++++++
 tb/tb_mem_wb_stage.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_stage_if.sv
// MEM -> WB pipeline bus: the instruction record handed from the memory-access
// stage to the write-back stage. The MEM stage is the master and the WB stage
// is the slave.
interface mem_wb_stage_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [1:0]        mem_ld;
  logic              mem_ld_signed;
  logic [1:0]        mem_ld_off;

  modport master (
    output mem_we, mem_waddr, mem_wdata, mem_ld, mem_ld_signed, mem_ld_off
  );

  modport slave (
    input mem_we, mem_waddr, mem_wdata, mem_ld, mem_ld_signed, mem_ld_off
  );
endinterface

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register plus write-back data selection.
// Captures the MEM-stage instruction record, applies stall/flush, aligns
// and extends load data from the synchronous data memory (big-endian byte
// lanes), drives the register file write port and counts retired writes.
//
// Build option WB_LOAD_EXT_EN: when defined, byte/half loads are aligned and
// sign/zero extended. When undefined, every load kind passes the memory word
// through unchanged and the signedness/offset attributes are not registered.
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                stall_mem,
  input  logic                stall_wb,
  mem_wb_stage_if.slave       mem,
  input  logic [DATA_W-1:0]   dmem_rdata,
  output logic                wb_we,
  output logic [ADDR_W-1:0]   wb_waddr,
  output logic [DATA_W-1:0]   wb_wdata,
  output logic [31:0]         retire_cnt
);

  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        ld_q, ld_d;
  logic [31:0]       retire_cnt_q, retire_cnt_d;

`ifdef WB_LOAD_EXT_EN
  logic              sgn_q, sgn_d;
  logic [1:0]        off_q, off_d;

  // Pick the addressed byte; offset 0 is the most significant lane.
  function automatic logic [7:0] sel_byte(input logic [DATA_W-1:0] w,
                                          input logic [1:0] off);
    case (off)
      2'd0:    sel_byte = w[DATA_W-1  -: 8];
      2'd1:    sel_byte = w[DATA_W-9  -: 8];
      2'd2:    sel_byte = w[DATA_W-17 -: 8];
      default: sel_byte = w[DATA_W-25 -: 8];
    endcase
  endfunction

  // Pick the addressed halfword; the low offset bit is ignored.
  function automatic logic [15:0] sel_half(input logic [DATA_W-1:0] w,
                                           input logic hi_off);
    sel_half = hi_off ? w[DATA_W-17 -: 16] : w[DATA_W-1 -: 16];
  endfunction

  // Widen a byte to DATA_W, replicating the sign bit when signed.
  function automatic logic [DATA_W-1:0] ext_byte(input logic [7:0] b,
                                                 input logic s);
    logic signed [7:0] bs;
    bs = b;
    ext_byte = s ? DATA_W'(bs) : DATA_W'(b);
  endfunction

  // Widen a halfword to DATA_W, replicating the sign bit when signed.
  function automatic logic [DATA_W-1:0] ext_half(input logic [15:0] h,
                                                 input logic s);
    logic signed [15:0] hs;
    hs = h;
    ext_half = s ? DATA_W'(hs) : DATA_W'(h);
  endfunction
`else
  // Load attributes are don't-care in pass-through mode.
  logic unused_ld_attr;
  assign unused_ld_attr = ^{mem.mem_ld_signed, mem.mem_ld_off};
`endif

  // Next stage contents: flush > bubble on MEM stall > hold on joint stall > capture.
  always_comb begin
    we_d    = we_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    ld_d    = ld_q;
`ifdef WB_LOAD_EXT_EN
    sgn_d   = sgn_q;
    off_d   = off_q;
`endif
    if (flush || (stall_mem && !stall_wb)) begin
      we_d    = 1'b0;
      waddr_d = '0;
      wdata_d = '0;
      ld_d    = 2'b00;
`ifdef WB_LOAD_EXT_EN
      sgn_d   = 1'b0;
      off_d   = 2'b00;
`endif
    end else if (!stall_mem) begin
      we_d    = mem.mem_we;
      waddr_d = mem.mem_waddr;
      wdata_d = mem.mem_wdata;
      ld_d    = mem.mem_ld;
`ifdef WB_LOAD_EXT_EN
      sgn_d   = mem.mem_ld_signed;
      off_d   = mem.mem_ld_off;
`endif
    end
  end

  // Stage register; reset forces a bubble at any time.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      ld_q    <= 2'b00;
`ifdef WB_LOAD_EXT_EN
      sgn_q   <= 1'b0;
      off_q   <= 2'b00;
`endif
    end else begin
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      ld_q    <= ld_d;
`ifdef WB_LOAD_EXT_EN
      sgn_q   <= sgn_d;
      off_q   <= off_d;
`endif
    end
  end

  // Register-file write port, combinational from the stage and the memory word.
  always_comb begin
    wb_we    = we_q && (waddr_q != '0);
    wb_waddr = waddr_q;
    case (ld_q)
      2'b00:   wb_wdata = wdata_q;
`ifdef WB_LOAD_EXT_EN
      2'b01:   wb_wdata = ext_byte(sel_byte(dmem_rdata, off_q), sgn_q);
      2'b10:   wb_wdata = ext_half(sel_half(dmem_rdata, off_q[1]), sgn_q);
`endif
      default: wb_wdata = dmem_rdata;
    endcase
  end

  // A write retires on the edge where it leaves WB (not stalled); wraps naturally.
  always_comb begin
    retire_cnt_d = retire_cnt_q + 32'(wb_we && !stall_wb);
  end

  // Retired-write counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retire_cnt_q <= '0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed cases followed by random
// traffic, all compared against a transaction-level model of the WB slot.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush, stall_mem, stall_wb;
  logic [31:0] dmem_rdata;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic [31:0] retire_cnt;

  mem_wb_stage_if #(.DATA_W(32), .ADDR_W(5)) mif ();

  mem_wb_stage #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .stall_mem  (stall_mem),
    .stall_wb   (stall_wb),
    .mem        (mif),
    .dmem_rdata (dmem_rdata),
    .wb_we      (wb_we),
    .wb_waddr   (wb_waddr),
    .wb_wdata   (wb_wdata),
    .retire_cnt (retire_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: the instruction currently occupying WB, and the retire count.
  logic        m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  logic [1:0]  m_ld;
  logic        m_sgn;
  logic [1:0]  m_off;
  logic [31:0] m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_ld = '0; m_sgn = 1'b0; m_off = '0;
  endtask

  function automatic logic model_we();
    return m_we && (m_waddr != 5'd0);
  endfunction

  // Expected write data from the load rules, using shifts and masks.
  function automatic logic [31:0] model_wdata(input logic [31:0] rd);
    logic [31:0] v;
    if (m_ld == 2'b00) return m_wdata;
`ifdef WB_LOAD_EXT_EN
    if (m_ld == 2'b01) begin
      v = (rd >> (8 * (3 - int'(m_off)))) & 32'h0000_00FF;
      if (m_sgn && v[7]) v = v | 32'hFFFF_FF00;
      return v;
    end
    if (m_ld == 2'b10) begin
      v = (rd >> (m_off[1] ? 0 : 16)) & 32'h0000_FFFF;
      if (m_sgn && v[15]) v = v | 32'hFFFF_0000;
      return v;
    end
`endif
    return rd;
  endfunction

  // One clock: drive inputs at the falling edge, check outputs, advance model.
  task automatic cycle(input logic f, input logic sm, input logic sw,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [1:0] ld, input logic sg, input logic [1:0] of,
                       input logic [31:0] rd);
    @(negedge clk);
    flush = f; stall_mem = sm; stall_wb = sw;
    mif.mem_we = we; mif.mem_waddr = wa; mif.mem_wdata = wd;
    mif.mem_ld = ld; mif.mem_ld_signed = sg; mif.mem_ld_off = of;
    dmem_rdata = rd;
    #1;
    check("wb_we",      {31'd0, wb_we}, {31'd0, model_we()});
    check("wb_waddr",   {27'd0, wb_waddr}, {27'd0, m_waddr});
    check("wb_wdata",   wb_wdata, model_wdata(rd));
    check("retire_cnt", retire_cnt, m_cnt);
    if (model_we() && !sw) m_cnt = m_cnt + 32'd1;
    if (f || (sm && !sw)) model_clear();
    else if (!sm) begin
      m_we = we; m_waddr = wa; m_wdata = wd; m_ld = ld; m_sgn = sg; m_off = of;
    end
  endtask

  task automatic nop(input logic [31:0] rd);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 2'b00, 1'b0, 2'b00, rd);
  endtask

  task automatic zero_inputs();
    flush = 0; stall_mem = 0; stall_wb = 0; dmem_rdata = '0;
    mif.mem_we = 0; mif.mem_waddr = '0; mif.mem_wdata = '0;
    mif.mem_ld = '0; mif.mem_ld_signed = 0; mif.mem_ld_off = '0;
  endtask

  // Assert reset between edges and confirm outputs clear without a clock.
  task automatic async_reset(input string tag);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check({tag, "_we"},    {31'd0, wb_we}, 32'd0);
    check({tag, "_waddr"}, {27'd0, wb_waddr}, 32'd0);
    check({tag, "_wdata"}, wb_wdata, 32'd0);
    check({tag, "_cnt"},   retire_cnt, 32'd0);
    model_clear();
    m_cnt = '0;
    zero_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  logic [1:0]  lk_ld  [4] = '{2'b01, 2'b01, 2'b10, 2'b11};
  logic        lk_sg  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic [1:0]  lk_off [4] = '{2'd0, 2'd3, 2'd2, 2'd0};
`ifdef WB_LOAD_EXT_EN
  logic [31:0] lk_exp [4] = '{32'hFFFF_FF80, 32'h0000_0001, 32'h0000_7F01, 32'h80FF_7F01};
`else
  logic [31:0] lk_exp [4] = '{32'h80FF_7F01, 32'h80FF_7F01, 32'h80FF_7F01, 32'h80FF_7F01};
`endif

  logic [31:0] c0;

  initial begin
    rst = 1'b0;
    zero_inputs();
    model_clear();
    m_cnt = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_we",    {31'd0, wb_we}, 32'd0);
    check("rst_wdata", wb_wdata, 32'd0);
    check("rst_cnt",   retire_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // ALU write to r3
    cycle(0, 0, 0, 1, 5'd3, 32'h1234_5678, 2'b00, 0, 2'd0, 32'hDEAD_BEEF);
    nop(32'h0);
    check("alu_we",    {31'd0, wb_we}, 32'd1);
    check("alu_wdata", wb_wdata, 32'h1234_5678);
    nop(32'h0);
    check("alu_cnt",   retire_cnt, 32'd1);

    // Write to r0 never asserts and never counts
    cycle(0, 0, 0, 1, 5'd0, 32'hAAAA_5555, 2'b00, 0, 2'd0, 32'h0);
    nop(32'h0);
    check("r0_we", {31'd0, wb_we}, 32'd0);
    nop(32'h0);
    check("r0_cnt", retire_cnt, 32'd1);

    // Load alignment with the memory word presented in the WB cycle
    for (int k = 0; k < 4; k++) begin
      cycle(0, 0, 0, 1, 5'd7, 32'h0, lk_ld[k], lk_sg[k], lk_off[k], 32'h0);
      nop(32'h80FF_7F01);
      check($sformatf("load%0d", k), wb_wdata, lk_exp[k]);
    end

    // MEM stall alone inserts a bubble
    cycle(0, 1, 0, 1, 5'd4, 32'h0000_00AA, 2'b00, 0, 2'd0, 32'h0);
    nop(32'h0);
    check("bubble_we", {31'd0, wb_we}, 32'd0);

    // Joint stall holds the instruction and counts it once
    cycle(0, 0, 0, 1, 5'd9, 32'h0000_0BBB, 2'b00, 0, 2'd0, 32'h0);
    c0 = m_cnt;
    for (int k = 0; k < 3; k++) begin
      cycle(0, 1, 1, 1, 5'd12, 32'h0000_0CCC, 2'b00, 0, 2'd0, 32'h0);
      check("hold_waddr", {27'd0, wb_waddr}, 32'd9);
      check("hold_cnt",   retire_cnt, c0);
    end
    nop(32'h0);
    nop(32'h0);
    check("hold_cnt_once", retire_cnt, c0 + 32'd1);

    // Flush with WB stall becomes a bubble
    cycle(0, 0, 0, 1, 5'd10, 32'h0000_0DDD, 2'b00, 0, 2'd0, 32'h0);
    cycle(1, 1, 1, 1, 5'd11, 32'h0000_0EEE, 2'b00, 0, 2'd0, 32'h0);
    nop(32'h0);
    check("flush_we", {31'd0, wb_we}, 32'd0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0, 1'($urandom), 5'($urandom), $urandom,
            2'($urandom), 1'($urandom), 2'($urandom), $urandom);
    end

    // Counter wrap
    nop(32'h0);
    cycle(0, 0, 0, 1, 5'd2, 32'h0000_0022, 2'b00, 0, 2'd0, 32'h0);
    @(posedge clk);
    #1;
    force dut.retire_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_cnt_q;
    m_cnt = 32'hFFFF_FFFF;
    nop(32'h0);
    nop(32'h0);
    check("wrap_cnt", retire_cnt, 32'd0);

    // Reset in the middle of a joint stall
    cycle(0, 0, 0, 1, 5'd6, 32'h0000_0066, 2'b00, 0, 2'd0, 32'h0);
    cycle(0, 1, 1, 0, 5'd0, 32'h0, 2'b00, 0, 2'd0, 32'h0);
    async_reset("midrst");
    nop(32'h0);
    cycle(0, 0, 0, 1, 5'd5, 32'h0000_0055, 2'b00, 0, 2'd0, 32'h0);
    nop(32'h0);
    nop(32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
